taxi_fare_ctrl: RTL and testbench

TAXI_FARE_CTRL -- requirements
Module: taxi_fare_ctrl

---
 rtl/taxi_fare_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_taxi_fare_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/taxi_fare_ctrl.sv
// Taxi meter core: debounced hire/stop button, wheel-pulse odometer, distance and waiting fare.
// Latency: wheel pin edge reaches dist_m on the 3rd clock edge; button press acts DEB_CYC+3 edges after pin settles.
// Backpressure: none; free-running inputs, every output is a register updated each cycle.
//
// Ports:
//   sys_clk, sys_rst       clock and synchronous active-high reset
//   pulse_port, stat_port  raw asynchronous wheel pulse and hire/stop button
//   price                  fare in 0.01 yuan, saturating at PRICE_MAX
//   dist_m                 trip distance in metres, saturating at 65535
//   point, seg_en, sign    display controls (two decimals while shown, sign always 0)
//   stat_led, dist_led     hired indicator and 100 m toggle
module taxi_fare_ctrl #(
  parameter int unsigned DEB_CYC   = 1_000_000,
  parameter int unsigned BASE_FARE = 1000,
  parameter int unsigned BASE_DIST = 3000,
  parameter int unsigned UNIT_FARE = 20,
  parameter logic [31:0] WAIT_CYC  = 32'd3_000_000_000,
  parameter int unsigned WAIT_FARE = 50,
  parameter int unsigned PRICE_MAX = 999999
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        pulse_port,
  input  logic        stat_port,
  output logic [19:0] price,
  output logic [15:0] dist_m,
  output logic [5:0]  point,
  output logic        seg_en,
  output logic        sign,
  output logic        stat_led,
  output logic        dist_led
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_t;

  localparam int                DEB_W     = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
  localparam logic [31:0]       WAIT_LAST = WAIT_CYC - 32'd1;

  state_t            state, state_nxt;
  logic              pulse_s1, pulse_s2, pulse_d;
  logic              stat_s1, stat_s2;
  logic [1:0]        sync_vld;
  logic [DEB_W-1:0]  deb_cnt;
  logic              stat_deb, stat_deb_d;
  logic              armed;
  logic              press, pulse_edge;
  logic [6:0]        sub_cnt, sub_nxt;
  logic [31:0]       wait_cnt, wait_nxt;
  logic [19:0]       price_nxt;
  logic [15:0]       dist_nxt;
  logic              dled_nxt;
  logic              dist_chg, wait_chg;
  logic [21:0]       price_sum;

  // Synchronizers, button debounce and press arming.
  // sync_vld marks when stat_s2 reflects the pin again after reset; the button
  // only becomes armed once it has been seen released, so a button held down
  // across reset release cannot produce a press.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pulse_s1   <= 1'b0;
      pulse_s2   <= 1'b0;
      pulse_d    <= 1'b0;
      stat_s1    <= 1'b0;
      stat_s2    <= 1'b0;
      sync_vld   <= 2'b00;
      deb_cnt    <= '0;
      stat_deb   <= 1'b0;
      stat_deb_d <= 1'b0;
      armed      <= 1'b0;
    end else begin
      pulse_s1   <= pulse_port;
      pulse_s2   <= pulse_s1;
      pulse_d    <= pulse_s2;
      stat_s1    <= stat_port;
      stat_s2    <= stat_s1;
      sync_vld   <= {sync_vld[0], 1'b1};
      stat_deb_d <= stat_deb;
      if (sync_vld[1] && !stat_s2) armed <= 1'b1;
      // Any cycle where the synchronized level agrees with the debounced one restarts the count.
      if (stat_s2 != stat_deb) begin
        if (deb_cnt == DEB_LAST) begin
          stat_deb <= stat_s2;
          deb_cnt  <= '0;
        end else begin
          deb_cnt <= deb_cnt + DEB_W'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  assign press      = stat_deb & ~stat_deb_d & armed;
  assign pulse_edge = pulse_s2 & ~pulse_d;

  // FSM state register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  // FSM next state: each press steps IDLE -> RUN -> STOP -> IDLE
  always_comb begin
    state_nxt = state;
    if (press) begin
      case (state)
        IDLE:    state_nxt = RUN;
        RUN:     state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Fare and odometer next values. A press in RUN freezes everything, so a
  // wheel pulse landing in the RUN->STOP cycle is dropped.
  always_comb begin
    price_nxt = price;
    dist_nxt  = dist_m;
    sub_nxt   = sub_cnt;
    wait_nxt  = wait_cnt;
    dled_nxt  = dist_led;
    dist_chg  = 1'b0;
    wait_chg  = 1'b0;
    price_sum = '0;
    case (state)
      IDLE: begin
        if (press) begin
          price_nxt = 20'(BASE_FARE);
          dist_nxt  = '0;
          sub_nxt   = '0;
          wait_nxt  = '0;
        end else begin
          price_nxt = '0;
          dist_nxt  = '0;
        end
      end
      RUN: begin
        if (!press) begin
          if (pulse_edge) begin
            // Wheel movement restarts the waiting interval.
            wait_nxt = '0;
            if (dist_m != 16'hFFFF) dist_nxt = dist_m + 16'd1;
            if (sub_cnt == 7'd99) begin
              sub_nxt  = '0;
              dled_nxt = ~dist_led;
              dist_chg = (32'(dist_nxt) > BASE_DIST);
            end else begin
              sub_nxt = sub_cnt + 7'd1;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            wait_nxt = '0;
            wait_chg = 1'b1;
          end else begin
            wait_nxt = wait_cnt + 32'd1;
          end
          price_sum = 22'(price) + (dist_chg ? 22'(UNIT_FARE) : 22'd0)
                                 + (wait_chg ? 22'(WAIT_FARE) : 22'd0);
          price_nxt = (price_sum > 22'(PRICE_MAX)) ? 20'(PRICE_MAX) : price_sum[19:0];
        end
      end
      STOP: begin
        if (press) begin
          price_nxt = '0;
          dist_nxt  = '0;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs; display controls follow the state being entered so
  // they change on the same edge as price/dist_m.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      price    <= '0;
      dist_m   <= '0;
      sub_cnt  <= '0;
      wait_cnt <= '0;
      dist_led <= 1'b0;
      seg_en   <= 1'b0;
      stat_led <= 1'b0;
      point    <= '0;
      sign     <= 1'b0;
    end else begin
      price    <= price_nxt;
      dist_m   <= dist_nxt;
      sub_cnt  <= sub_nxt;
      wait_cnt <= wait_nxt;
      dist_led <= dled_nxt;
      seg_en   <= (state_nxt != IDLE);
      stat_led <= (state_nxt == RUN);
      point    <= (state_nxt != IDLE) ? 6'b000100 : 6'b000000;
      sign     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_taxi_fare_ctrl.sv
// Bench for taxi_fare_ctrl: vector table, corner sequences and random trips vs. a fare model.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled there too.
// Backpressure: not applicable.
module tb_taxi_fare_ctrl;

  localparam int T_BASE_FARE = 1000;
  localparam int T_BASE_DIST = 3000;
  localparam int T_UNIT_FARE = 20;
  localparam int T_WAIT_CYC  = 1000;
  localparam int T_WAIT_FARE = 50;
  localparam int T_PRICE_MAX = 999999;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        pulse_port = 1'b0;
  logic        stat_port = 1'b0;
  logic [19:0] price, s_price;
  logic [15:0] dist_m, s_dist_m;
  logic [5:0]  point, s_point;
  logic        seg_en, sign, stat_led, dist_led;
  logic        s_seg_en, s_sign, s_stat_led, s_dist_led;

  taxi_fare_ctrl #(.DEB_CYC(4), .WAIT_CYC(32'd1000)) u_dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .pulse_port(pulse_port), .stat_port(stat_port),
    .price(price), .dist_m(dist_m), .point(point), .seg_en(seg_en), .sign(sign),
    .stat_led(stat_led), .dist_led(dist_led));

  // Second instance starting near the price ceiling with a short waiting unit.
  taxi_fare_ctrl #(.DEB_CYC(4), .BASE_FARE(999_900), .WAIT_CYC(32'd10)) u_sat (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .pulse_port(pulse_port), .stat_port(stat_port),
    .price(s_price), .dist_m(s_dist_m), .point(s_point), .seg_en(s_seg_en), .sign(s_sign),
    .stat_led(s_stat_led), .dist_led(s_dist_led));

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  int press_e, last_pe, r2;
  int pe_q[$];
  bit dled_ref;

  typedef struct {
    int act;   // 0 glitch high arg cycles, 1 press, 2 arg pulses, 3 idle arg cycles
    int arg;
    int p;
    int d;
    bit seg;
    bit sled;
    bit dled;
  } vec_t;
  vec_t vt[4];

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int p, input int d,
                         input bit seg, input bit sled, input bit dled);
    chk({tag, ".price"}, price, p);
    chk({tag, ".dist_m"}, dist_m, d);
    chk({tag, ".seg_en"}, seg_en, seg);
    chk({tag, ".stat_led"}, stat_led, sled);
    chk({tag, ".dist_led"}, dist_led, dled);
    chk({tag, ".point"}, point, seg ? 4 : 0);
    chk({tag, ".sign"}, sign, 0);
  endtask

  // Clean press: pin high 10 cycles then low 10. The FSM acts 7 edges after
  // the pin rises (2 sync flops, 4 debounce cycles, 1 press cycle).
  task automatic press_btn();
    press_e   = cyc + 7;
    stat_port = 1'b1;
    tick(10);
    stat_port = 1'b0;
    tick(10);
  endtask

  // One wheel pulse, counted on the 3rd edge after the pin rises.
  task automatic pulse_one(input int gap);
    last_pe = cyc + 3;
    pe_q.push_back(last_pe);
    pulse_port = 1'b1;
    tick(2);
    pulse_port = 1'b0;
    tick(gap - 2);
  endtask

  task automatic pulses(input int n);
    repeat (n) pulse_one(4);
  endtask

  // Fare from a trip entered on edge r, looking at edge e: distance, charged
  // hundreds beyond the base distance, and whole waiting units in each
  // pulse-free stretch.
  function automatic void model(input int r, input int e, output int p, output int d, output int tog);
    int  prev;
    int  n;
    int  hc;
    longint w;
    longint pl;
    prev = r;
    n    = 0;
    w    = 0;
    foreach (pe_q[k]) begin
      if (pe_q[k] > r && pe_q[k] <= e) begin
        w += (pe_q[k] - prev - 1) / T_WAIT_CYC;
        prev = pe_q[k];
        n++;
      end
    end
    w += (e - prev) / T_WAIT_CYC;
    hc = 0;
    for (int k = 100; k <= n; k += 100)
      if (k > T_BASE_DIST) hc++;
    pl = T_BASE_FARE + T_UNIT_FARE * hc + T_WAIT_FARE * w;
    p   = (pl > T_PRICE_MAX) ? T_PRICE_MAX : int'(pl);
    d   = (n > 65535) ? 65535 : n;
    tog = n / 100;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before the end of the test");
    $fatal(1, "time limit");
  end

  initial begin
    vt[0] = '{0, 3,    0,    0,    0, 0, 0};
    vt[1] = '{1, 0,    1000, 0,    1, 1, 0};
    vt[2] = '{2, 3100, 1020, 3100, 1, 1, 1};
    vt[3] = '{3, 2000, 1120, 3100, 1, 1, 1};

    // Reset state
    tick(3);
    chk_out("reset", 0, 0, 0, 0, 0);
    sys_rst = 1'b0;
    tick(5);

    // Vector table: glitch, press, 3100 m, 2000 idle cycles
    for (int i = 0; i < 4; i++) begin
      case (vt[i].act)
        0: begin stat_port = 1'b1; tick(vt[i].arg); stat_port = 1'b0; end
        1: press_btn();
        2: pulses(vt[i].arg);
        default: tick(vt[i].arg);
      endcase
      tick(4);
      chk_out($sformatf("vec%0d", i), vt[i].p, vt[i].d, vt[i].seg, vt[i].sled, vt[i].dled);
    end

    // Pulse on the last cycle of a waiting unit: no charge; a full unit later: charge
    tick(last_pe + 2997 - cyc);
    pulse_one(6);
    tick(4);
    chk("wait999.price", price, 1120);
    chk("wait999.dist_m", dist_m, 3101);
    tick(last_pe + 999 - cyc);
    chk("unit_minus1.price", price, 1120);
    tick(1);
    chk("unit_full.price", price, 1170);

    // Press during a pulse train; the pulse landing on the transition edge is dropped
    for (int i = 0; i < 40; i++) begin
      if (i == 20) stat_port = 1'b1;
      if (i == 25) stat_port = 1'b0;
      pulse_one(4);
    end
    tick(8);
    chk_out("stop_frz", 1170, 3122, 1, 0, 1);
    pulses(10);
    tick(1504);
    chk_out("stop_hold", 1170, 3122, 1, 0, 1);
    press_btn();
    tick(4);
    chk_out("to_idle", 0, 0, 0, 0, 1);

    // Second trip: waiting charges from a fresh start, ceiling on the second instance
    press_btn();
    r2 = press_e;
    chk("sat_unit1", s_price, 999950);
    tick(10);
    chk("sat_clamp", s_price, 999999);
    tick(10);
    chk("sat_hold", s_price, 999999);
    tick(r2 + 1999 - cyc);
    chk("wait_1999.price", price, 1050);
    tick(1);
    chk("wait_2000.price", price, 1100);
    pulses(250);
    tick(4);
    chk_out("run250", 1100, 250, 1, 1, 1);

    // Reset mid-trip
    sys_rst = 1'b1;
    tick(1);
    chk_out("rst_run", 0, 0, 0, 0, 0);
    sys_rst = 1'b0;

    // Button held across reset release must not start a trip
    stat_port = 1'b1;
    sys_rst   = 1'b1;
    tick(2);
    sys_rst = 1'b0;
    tick(40);
    chk_out("rst_held", 0, 0, 0, 0, 0);
    stat_port = 1'b0;
    tick(20);
    press_btn();
    tick(2);
    chk_out("rearm", 1000, 0, 1, 1, 0);
    press_btn();
    press_btn();
    tick(4);
    chk_out("rearm_idle", 0, 0, 0, 0, 0);

    // Random trips against the fare model
    dled_ref = 1'b0;
    for (int t = 0; t < 2; t++) begin
      int n, longs, p, d, tog, r, gap;
      pe_q.delete();
      press_btn();
      r = press_e;
      n = (t == 0) ? int'($urandom_range(3300, 2900)) : int'($urandom_range(1500, 100));
      longs = 0;
      for (int k = 0; k < n; k++) begin
        gap = $urandom_range(8, 4);
        if (longs < 5 && $urandom_range(499, 0) == 0) begin
          gap = $urandom_range(2100, 900);
          longs++;
        end
        pulse_one(gap);
      end
      tick(4);
      model(r, cyc, p, d, tog);
      dled_ref ^= tog[0];
      chk($sformatf("trip%0d.price", t), price, p);
      chk($sformatf("trip%0d.dist_m", t), dist_m, d);
      chk($sformatf("trip%0d.dist_led", t), dist_led, dled_ref);
      press_btn();
      model(r, press_e - 1, p, d, tog);
      tick(4);
      chk_out($sformatf("trip%0d_stop", t), p, d, 1, 0, dled_ref);
      press_btn();
      tick(4);
      chk_out($sformatf("trip%0d_idle", t), 0, 0, 0, 0, dled_ref);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
